// File: rtl/pipe_arbiter.sv
// pipe_arbiter: two-requester scheduler for the 4-stage add/select/multiply
// pipeline (d2 = d1+a, d3 = ctl?c:d2, d4 = e*d3). It issues one op per cycle,
// skews operands to their consuming stage, tracks per-stage valid/tag and
// returns results with ready/valid backpressure through a global stage enable.
// Build option: PIPE_ARB_FIXED_PRIO_EN gives requester 0 fixed priority
// (no round-robin pointer); undefined selects round-robin arbitration.
module pipe_arbiter #(
  parameter int unsigned W  = 8,
  parameter int unsigned OW = 2 * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [4*W:0]  req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [4*W:0]  req1_op,
  output logic          pipe_en,
  output logic [W-1:0]  pipe_d,
  output logic [W-1:0]  pipe_a,
  output logic [W-1:0]  pipe_c,
  output logic          pipe_ctl,
  output logic [W-1:0]  pipe_e,
  input  logic [OW-1:0] pipe_d4,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_data,
  output logic          res_tag,
  output logic          busy
);

  localparam int unsigned OPW = 4 * W + 1;

  logic [4:1]    v;
  logic [4:1]    tag;
  logic          gnt0;
  logic          gnt1;
  logic          issue;
  logic [OPW-1:0] sel_op;
  logic [W-1:0]  op_d;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_c;
  logic [W-1:0]  op_e;
  logic          op_ctl;

  // Skew registers: a one stage, {c,ctl} two stages, e three stages
  logic [W-1:0]  a_s1;
  logic [W-1:0]  c_s1;
  logic [W-1:0]  c_s2;
  logic          ctl_s1;
  logic          ctl_s2;
  logic [W-1:0]  e_s1;
  logic [W-1:0]  e_s2;
  logic [W-1:0]  e_s3;

`ifndef PIPE_ARB_FIXED_PRIO_EN
  logic          rr_ptr;
`endif

  // Stall the whole pipe while an unconsumed result sits in stage 4, and hold during reset
  assign pipe_en = reset & ~(v[4] & ~res_ready);

  // Arbitration between the two requesters
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef PIPE_ARB_FIXED_PRIO_EN
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      gnt0 = ~rr_ptr;
      gnt1 = rr_ptr;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
`endif
  end

  assign req0_ready = pipe_en & gnt0;
  assign req1_ready = pipe_en & gnt1;
  assign issue      = req0_ready | req1_ready;

  // Granted op fields; non-issue cycles inject a zero bubble
  always_comb begin
    sel_op = req1_ready ? req1_op : req0_op;
    op_d   = sel_op[W-1:0];
    op_a   = sel_op[2*W-1:W];
    op_c   = sel_op[3*W-1:2*W];
    op_e   = sel_op[4*W-1:3*W];
    op_ctl = sel_op[4*W];
    pipe_d = issue ? op_d : '0;
  end

  // Per-stage valid/tag tracking and operand skew, advancing only on pipe_en
  always_ff @(posedge clk) begin
    if (!reset) begin
      v      <= '0;
      tag    <= '0;
      a_s1   <= '0;
      c_s1   <= '0;
      c_s2   <= '0;
      ctl_s1 <= 1'b0;
      ctl_s2 <= 1'b0;
      e_s1   <= '0;
      e_s2   <= '0;
      e_s3   <= '0;
    end else if (pipe_en) begin
      v      <= {v[3:1], issue};
      tag    <= {tag[3:1], req1_ready};
      a_s1   <= issue ? op_a : '0;
      c_s1   <= issue ? op_c : '0;
      ctl_s1 <= issue & op_ctl;
      e_s1   <= issue ? op_e : '0;
      c_s2   <= c_s1;
      ctl_s2 <= ctl_s1;
      e_s2   <= e_s1;
      e_s3   <= e_s2;
    end
  end

`ifndef PIPE_ARB_FIXED_PRIO_EN
  // Round-robin pointer flips to the loser after every contended grant
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (pipe_en && req0_valid && req1_valid) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  assign pipe_a    = a_s1;
  assign pipe_c    = c_s2;
  assign pipe_ctl  = ctl_s2;
  assign pipe_e    = e_s3;
  assign res_valid = v[4];
  assign res_tag   = tag[4];
  assign res_data  = pipe_d4;
  assign busy      = |v;

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter: directed bench for pipe_arbiter with a behavioural
// add/select/multiply datapath wrapped around the controller.
module tb_pipe_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [4*W:0]  req0_op = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [4*W:0]  req1_op = '0;
  logic          pipe_en;
  logic [W-1:0]  pipe_d;
  logic [W-1:0]  pipe_a;
  logic [W-1:0]  pipe_c;
  logic          pipe_ctl;
  logic [W-1:0]  pipe_e;
  logic [OW-1:0] pipe_d4;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [OW-1:0] res_data;
  logic          res_tag;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_arbiter #(.W(W), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .pipe_en(pipe_en), .pipe_d(pipe_d), .pipe_a(pipe_a), .pipe_c(pipe_c),
    .pipe_ctl(pipe_ctl), .pipe_e(pipe_e), .pipe_d4(pipe_d4),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath: all stages load together on pipe_en and are never reset
  logic [W-1:0]  dp_d1 = '0;
  logic [W-1:0]  dp_d2 = '0;
  logic [W-1:0]  dp_d3 = '0;
  logic [OW-1:0] dp_d4 = '0;
  always @(posedge clk) begin
    if (pipe_en) begin
      dp_d1 <= pipe_d;
      dp_d2 <= dp_d1 + pipe_a;
      dp_d3 <= pipe_ctl ? pipe_c : dp_d2;
      dp_d4 <= OW'(pipe_e) * OW'(dp_d3);
    end
  end
  assign pipe_d4 = dp_d4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*W:0] mk(input logic ctl, input logic [W-1:0] e,
                                      input logic [W-1:0] c, input logic [W-1:0] a,
                                      input logic [W-1:0] d);
    return {ctl, e, c, a, d};
  endfunction

  typedef struct {
    logic          req1;
    logic          ctl;
    logic [W-1:0]  e;
    logic [W-1:0]  c;
    logic [W-1:0]  a;
    logic [W-1:0]  d;
    logic [OW-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  logic [OW-1:0] burst_exp[6];
  logic          burst_tag[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int got;
    int idx;
    logic found;
    logic accepted;

    vecs[0] = '{1'b0, 1'b0, 8'd5,   8'd0,   8'd4,  8'd3,   16'h0023};
    vecs[1] = '{1'b1, 1'b1, 8'd10,  8'd9,   8'd7,  8'd200, 16'h005A};
    vecs[2] = '{1'b0, 1'b0, 8'd3,   8'd0,   8'd10, 8'd250, 16'h000C};
    vecs[3] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd0,  8'd0,   16'hFE01};
    vecs[4] = '{1'b0, 1'b0, 8'd200, 8'd77,  8'd0,  8'd0,   16'h0000};
    vecs[5] = '{1'b1, 1'b0, 8'd16,  8'd0,   8'd1,  8'd15,  16'h0100};

`ifdef PIPE_ARB_FIXED_PRIO_EN
    burst_exp = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18};
    burst_tag = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    burst_exp = '{16'd3, 16'd10, 16'd9, 16'd20, 16'd15, 16'd30};
    burst_tag = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    // Reset state, with a pending request that must not be accepted
    req0_valid = 1'b1;
    req0_op    = mk(1'b0, 8'd1, 8'd1, 8'd1, 8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b0;
    @(posedge clk); #1;

    // Single-shot vectors: latency, result, tag, busy drop
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].req1) begin
        req1_valid = 1'b1;
        req1_op    = mk(vecs[i].ctl, vecs[i].e, vecs[i].c, vecs[i].a, vecs[i].d);
      end else begin
        req0_valid = 1'b1;
        req0_op    = mk(vecs[i].ctl, vecs[i].e, vecs[i].c, vecs[i].a, vecs[i].d);
      end
      @(negedge clk);
      check($sformatf("v%0d_acc", i), 32'(vecs[i].req1 ? req1_ready : req0_ready), 32'd1);
      check($sformatf("v%0d_other_ready", i), 32'(vecs[i].req1 ? req0_ready : req1_ready), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 0;
      found = 1'b0;
      for (int n = 1; n <= 10 && !found; n++) begin
        @(negedge clk);
        if (res_valid) begin
          found = 1'b1;
          lat = n;
        end
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_data", i), 32'(res_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_tag", i), 32'(res_tag), 32'(vecs[i].req1));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_rv_after", i), 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Both requesters contending for 6 cycles, back-to-back results
    for (int j = 0; j < 12; j++) begin
      req0_valid = (j < 6);
      req1_valid = (j < 6);
      req0_op    = mk(1'b1, 8'd3, 8'(j + 1), 8'd0, 8'd0);
      req1_op    = mk(1'b1, 8'd5, 8'(j + 1), 8'd0, 8'd0);
      @(negedge clk);
      if (j < 6) begin
        check($sformatf("burst%0d_g0", j), 32'(req0_ready), 32'(!burst_tag[j]));
        check($sformatf("burst%0d_g1", j), 32'(req1_ready), 32'(burst_tag[j]));
      end
      if (j >= 4 && j < 10) begin
        check($sformatf("burst%0d_rv", j), 32'(res_valid), 32'd1);
        check($sformatf("burst%0d_data", j), 32'(res_data), 32'(burst_exp[j-4]));
        check($sformatf("burst%0d_tag", j), 32'(res_tag), 32'(burst_tag[j-4]));
      end else begin
        check($sformatf("burst%0d_rv_idle", j), 32'(res_valid), 32'd0);
      end
      @(posedge clk); #1;
    end

    // Backpressure: full pipe, consumer stalls 3 cycles, then drains in order
    idx = 0;
    got = 0;
    for (int j = 0; j < 40 && got < 6; j++) begin
      req0_valid = (idx < 6);
      req0_op    = mk(1'b1, 8'd7, 8'(idx + 1), 8'd0, 8'd0);
      res_ready  = !(j >= 4 && j <= 6);
      @(negedge clk);
      if (j >= 4 && j <= 6) begin
        check($sformatf("stall%0d_pipe_en", j), 32'(pipe_en), 32'd0);
        check($sformatf("stall%0d_ready", j), 32'(req0_ready), 32'd0);
        check($sformatf("stall%0d_rv", j), 32'(res_valid), 32'd1);
        check($sformatf("stall%0d_data", j), 32'(res_data), 32'd7);
        check($sformatf("stall%0d_tag", j), 32'(res_tag), 32'd0);
      end
      if (res_valid && res_ready) begin
        check($sformatf("drain%0d_data", got), 32'(res_data), 32'(7 * (got + 1)));
        check($sformatf("drain%0d_tag", got), 32'(res_tag), 32'd0);
        got++;
      end
      accepted = req0_valid & req0_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
    end
    res_ready  = 1'b1;
    req0_valid = 1'b0;
    check("drain_count", 32'(got), 32'd6);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("drain_extra%0d", j), 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Reset with 3 ops in flight drops them all
    req0_valid = 1'b1;
    req0_op    = mk(1'b0, 8'd1, 8'd0, 8'd1, 8'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    check("mid_rst_pipe_en", 32'(pipe_en), 32'd0);
    check("mid_rst_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rv", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_rv", j), 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
